// File: rtl/conv_pkg.sv
// Shared sizing for the convolution line buffer: pixel width, RAM geometry
// and the delay-length type used by the line-delay controller.
package conv_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;   // must not exceed 2**ADDR_W

    typedef logic [ADDR_W:0]   len_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] pixel_t;

    localparam len_t DEPTH_LEN = len_t'(DEPTH);

    // Out-of-range requests (zero, or longer than the RAM) fall back to the full depth.
    function automatic len_t clamp_len(input len_t req);
        if (req == '0 || req > DEPTH_LEN) begin
            return DEPTH_LEN;
        end
        return req;
    endfunction

endpackage

// File: rtl/line_delay_ctrl.sv
// Circular delay-line controller for the single-port line RAM: writes each
// accepted pixel at a wrapping pointer and forwards the value it overwrote.
module line_delay_ctrl
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              io_flush,
    input  logic [ADDR_W:0]   io_len,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [DATA_W-1:0] io_in_bits,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [DATA_W-1:0] io_out_bits,
    output logic [DATA_W-1:0] io_ram_data,
    output logic [ADDR_W-1:0] io_ram_addr,
    output logic              io_ram_we,
    input  logic [DATA_W-1:0] io_ram_q,
    output logic              io_primed,
    output logic [ADDR_W:0]   io_level
);

    addr_t wptr,  wptr_nxt;
    len_t  count, count_nxt;
    len_t  len_r, len_nxt;
    logic  pend,  pend_nxt;

    logic in_fire;
    logic full;
    logic at_wrap;

    // A pending output that is not being taken blocks the input, so the RAM
    // is never overwritten while its read value is still on display.
    assign io_in_ready = !reset && !io_flush && (!pend || io_out_ready);
    assign in_fire     = io_in_valid && io_in_ready;

    assign full    = (count == len_r);
    assign at_wrap = ({1'b0, wptr} == (len_r - len_t'(1)));

    assign io_ram_we   = in_fire;
    assign io_ram_addr = wptr;
    assign io_ram_data = io_in_bits;

    assign io_out_valid = pend;
    assign io_out_bits  = io_ram_q;

    assign io_primed = full;
    assign io_level  = count;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        wptr_nxt  = wptr;
        count_nxt = count;
        len_nxt   = len_r;
        pend_nxt  = pend;

        if (io_flush) begin
            wptr_nxt  = '0;
            count_nxt = '0;
            pend_nxt  = 1'b0;
            len_nxt   = clamp_len(io_len);
        end else if (in_fire) begin
            wptr_nxt = at_wrap ? '0 : wptr + 1'b1;
            if (!full) begin
                count_nxt = count + 1'b1;
            end else begin
                // Once full, every write displaces a pixel that becomes the next output.
                pend_nxt = 1'b1;
            end
        end else if (pend && io_out_ready) begin
            pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            wptr  <= '0;
            count <= '0;
            pend  <= 1'b0;
            len_r <= DEPTH_LEN;
        end else begin
            wptr  <= wptr_nxt;
            count <= count_nxt;
            pend  <= pend_nxt;
            len_r <= len_nxt;
        end
    end

endmodule

// File: tb/tb_line_delay_ctrl.sv
// Scoreboard bench for line_delay_ctrl: a behavioural RAM, a queue-based
// delay-line model, directed scenarios and a randomized soak.
module tb_line_delay_ctrl;
    import conv_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              io_flush;
    logic [ADDR_W:0]   io_len;
    logic              io_in_valid;
    logic              io_in_ready;
    logic [DATA_W-1:0] io_in_bits;
    logic              io_out_valid;
    logic              io_out_ready;
    logic [DATA_W-1:0] io_out_bits;
    logic [DATA_W-1:0] io_ram_data;
    logic [ADDR_W-1:0] io_ram_addr;
    logic              io_ram_we;
    logic [DATA_W-1:0] io_ram_q = '0;
    logic              io_primed;
    logic [ADDR_W:0]   io_level;

    always #5 clk = ~clk;

    line_delay_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .io_flush     (io_flush),
        .io_len       (io_len),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_bits   (io_in_bits),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_bits  (io_out_bits),
        .io_ram_data  (io_ram_data),
        .io_ram_addr  (io_ram_addr),
        .io_ram_we    (io_ram_we),
        .io_ram_q     (io_ram_q),
        .io_primed    (io_primed),
        .io_level     (io_level)
    );

    // Single-port RAM: a write returns the old content next cycle; q holds otherwise.
    logic [DATA_W-1:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (io_ram_we) begin
            io_ram_q         <= mem[io_ram_addr];
            mem[io_ram_addr] <= io_ram_data;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pixels since the last clear, the expected outputs
    // awaiting consumption, and the effective delay length.
    logic [DATA_W-1:0] hist[$];
    logic [DATA_W-1:0] exp_q[$];
    int  m_len = DEPTH;
    int  m_acc = 0;
    bit  armed = 1'b0;
    bit  m_accept = 1'b0;
    bit  exp_ready;
    int  exp_lvl;

    function automatic int model_len(input logic [ADDR_W:0] l);
        return (l >= 1 && l <= DEPTH) ? int'(l) : DEPTH;
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            exp_ready = !reset && !io_flush && (exp_q.size() == 0 || io_out_ready);
            exp_lvl   = (m_acc < m_len) ? m_acc : m_len;
            m_accept  = io_in_valid && exp_ready;

            check("in_ready",  io_in_ready,  exp_ready);
            check("out_valid", io_out_valid, exp_q.size() != 0);
            check("level",     io_level,     exp_lvl);
            check("primed",    io_primed,    exp_lvl == m_len);
            check("ram_we",    io_ram_we,    m_accept);
            check("ram_addr",  io_ram_addr,  m_acc % m_len);
            if (m_accept) check("ram_data", io_ram_data, io_in_bits);

            if (reset || io_flush) begin
                hist.delete();
                exp_q.delete();
                m_acc = 0;
                m_len = reset ? DEPTH : model_len(io_len);
            end else begin
                if (exp_q.size() != 0 && io_out_ready)
                    check("out_bits", io_out_bits, exp_q.pop_front());
                if (m_accept) begin
                    hist.push_back(io_in_bits);
                    m_acc++;
                    if (hist.size() > m_len) exp_q.push_back(hist.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic [ADDR_W:0] l);
        io_in_valid = 1'b0;
        io_flush    = 1'b1;
        io_len      = l;
        step();
        io_flush    = 1'b0;
    endtask

    // Present one pixel until it is accepted; ready_pct sets output readiness.
    task automatic send(input logic [DATA_W-1:0] v, input int ready_pct);
        int waited = 0;
        io_in_valid = 1'b1;
        io_in_bits  = v;
        forever begin
            io_out_ready = ($urandom_range(99) < ready_pct);
            step();
            if (m_accept) break;
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no accept expected accept of %0h", v);
                break;
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        io_flush     = 1'b0;
        io_len       = '0;
        io_in_valid  = 1'b0;
        io_in_bits   = '0;
        io_out_ready = 1'b0;
        step();
        armed = 1'b1;
        step();
        reset = 1'b0;
        step();

        // Basic delay of 4.
        do_flush(7'd4);
        for (int v = 1; v <= 8; v++) send(8'(v), 100);
        io_in_valid = 1'b0;
        step();
        step();

        // Backpressure right after the first output appears.
        do_flush(7'd4);
        for (int v = 1; v <= 5; v++) send(8'(v), 100);
        io_out_ready = 1'b0;
        io_in_bits   = 8'd6;
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_bits", io_out_bits, 8'd1);
            step();
        end
        for (int v = 6; v <= 10; v++) send(8'(v), 100);
        io_in_valid = 1'b0;
        step();
        step();

        // Full depth with wrap, then out-of-range lengths.
        do_flush(7'd0);
        for (int n = 0; n < 200; n++) send(8'(n), 100);
        do_flush(7'd100);
        for (int n = 0; n < 70; n++) send(8'($urandom_range(255)), 100);

        // Flush while an output is pending drops it.
        do_flush(7'd2);
        for (int v = 1; v <= 3; v++) send(8'(v), 100);
        io_in_valid  = 1'b0;
        io_out_ready = 1'b0;
        step();
        do_flush(7'd2);
        for (int v = 7; v <= 9; v++) send(8'(v), 100);
        io_in_valid = 1'b0;
        step();

        // Flush together with a valid pixel.
        io_in_valid = 1'b1;
        io_in_bits  = 8'hAA;
        io_flush    = 1'b1;
        io_len      = 7'd3;
        step();
        io_flush = 1'b0;
        for (int v = 0; v < 6; v++) send(8'($urandom_range(255)), 60);

        // Reset mid-stream.
        io_in_valid = 1'b1;
        reset       = 1'b1;
        step();
        reset = 1'b0;
        for (int v = 0; v < 70; v++) send(8'($urandom_range(255)), 80);

        // Randomized soak.
        for (int c = 0; c < 4000; c++) begin
            io_in_valid  = ($urandom_range(99) < 70);
            io_in_bits   = 8'($urandom_range(255));
            io_out_ready = ($urandom_range(99) < 70);
            io_flush     = ($urandom_range(999) < 8);
            io_len       = 7'($urandom_range(127));
            reset        = ($urandom_range(999) < 2);
            step();
        end
        reset       = 1'b0;
        io_flush    = 1'b0;
        io_in_valid = 1'b0;
        io_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
